branch_resolver: RTL and testbench

BRANCH_RESOLVER -- requirements
Module: branch_resolver

---
 rtl/branch_resolver.sv | 118 +++++++++++
 tb/tb_branch_resolver.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// Tracks fetched instructions against their predictions and resolves them at EXEC,
// issuing predictor-update pulses and fetch redirects one cycle after retirement.
module branch_resolver #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_valid,
  input  logic [31:0] f_pc,
  input  logic        f_predict_valid,
  input  logic [31:0] f_predict_addr,
  output logic        f_ready,
  input  logic        x_valid,
  input  logic [31:0] x_pc,
  input  logic        x_is_branch,
  input  logic        x_taken,
  input  logic [31:0] x_target,
  output logic        fb_valid,
  output logic [31:0] fb_pc,
  output logic        fb_taken,
  output logic        redirect_valid,
  output logic [31:0] redirect_addr,
  output logic        sync_err,
  output logic [15:0] branch_count,
  output logic [15:0] mispredict_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   pc_mem    [DEPTH];
  logic          taken_mem [DEPTH];
  logic [31:0]   addr_mem  [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic        pop_p0, push_p0, flush_p0, mismatch_p0, fb_p0;
  logic        empty_err_p0, overflow_p0;
  logic [31:0] head_pc, head_addr, pc4_p0, act_next_p0, pred_next_p0, redir_addr_p0;
  logic        head_taken;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    if (en && v != 16'hFFFF) return v + 16'd1;
    return v;
  endfunction

  assign f_ready = (count != FULL);

  // p0: resolve the EXEC instruction against the oldest in-flight prediction
  always_comb begin
    head_pc       = pc_mem[rd_ptr];
    head_taken    = taken_mem[rd_ptr];
    head_addr     = addr_mem[rd_ptr];
    pc4_p0        = x_pc + 32'd4;
    act_next_p0   = (x_is_branch && x_taken) ? x_target : pc4_p0;
    pred_next_p0  = head_taken ? head_addr : pc4_p0;
    pop_p0        = x_valid && (count != '0);
    empty_err_p0  = x_valid && (count == '0);
    mismatch_p0   = pop_p0 && (head_pc != x_pc);
    flush_p0      = pop_p0 && (mismatch_p0 || (pred_next_p0 != act_next_p0));
    redir_addr_p0 = mismatch_p0 ? pc4_p0 : act_next_p0;
    fb_p0         = pop_p0 && x_is_branch && !mismatch_p0;
    // A full FIFO still accepts a push when the same edge frees the head slot.
    overflow_p0   = f_valid && (count == FULL) && !pop_p0;
    push_p0       = f_valid && !redirect_valid && !flush_p0 && ((count != FULL) || pop_p0);
  end

  always_ff @(posedge clk) begin
    if (reset || flush_p0) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_p0) wr_ptr <= wr_ptr + 1'b1;
      if (pop_p0)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_p0, pop_p0})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_p0 && !reset) begin
      pc_mem[wr_ptr]    <= f_pc;
      taken_mem[wr_ptr] <= f_predict_valid;
      addr_mem[wr_ptr]  <= f_predict_addr;
    end
  end

  // p1: registered feedback, redirect and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      fb_valid         <= 1'b0;
      fb_pc            <= '0;
      fb_taken         <= 1'b0;
      redirect_valid   <= 1'b0;
      redirect_addr    <= '0;
      sync_err         <= 1'b0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      fb_valid       <= fb_p0;
      redirect_valid <= flush_p0;
      if (fb_p0) begin
        fb_pc    <= x_pc;
        fb_taken <= x_taken;
      end
      if (flush_p0) redirect_addr <= redir_addr_p0;
      sync_err         <= sync_err | mismatch_p0 | empty_err_p0 | overflow_p0;
      branch_count     <= sat_inc(branch_count, fb_p0);
      mispredict_count <= sat_inc(mispredict_count, flush_p0);
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed vector bench for branch_resolver: per-cycle stimulus table plus a streaming sequence.
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_valid, f_predict_valid, f_ready;
  logic [31:0] f_pc, f_predict_addr;
  logic        x_valid, x_is_branch, x_taken;
  logic [31:0] x_pc, x_target;
  logic        fb_valid, fb_taken, redirect_valid, sync_err;
  logic [31:0] fb_pc, redirect_addr;
  logic [15:0] branch_count, mispredict_count;

  int nvec  = 0;
  int nfail = 0;

  branch_resolver #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .f_valid(f_valid), .f_pc(f_pc), .f_predict_valid(f_predict_valid),
    .f_predict_addr(f_predict_addr), .f_ready(f_ready),
    .x_valid(x_valid), .x_pc(x_pc), .x_is_branch(x_is_branch), .x_taken(x_taken),
    .x_target(x_target),
    .fb_valid(fb_valid), .fb_pc(fb_pc), .fb_taken(fb_taken),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .sync_err(sync_err), .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        fv;
    logic [31:0] fpc;
    logic        fpv;
    logic [31:0] fpa;
    logic        xv;
    logic [31:0] xpc;
    logic        xbr;
    logic        xtk;
    logic [31:0] xtgt;
    logic        fbv;
    logic [31:0] fbpc;
    logic        fbt;
    logic        rv;
    logic [31:0] ra;
    logic        se;
    logic [15:0] bc;
    logic [15:0] mc;
    logic        fr;
  } vec_t;

  vec_t tv[$];

  task automatic drive(input logic rst, input logic fv, input logic [31:0] fpc,
                       input logic fpv, input logic [31:0] fpa, input logic xv,
                       input logic [31:0] xpc, input logic xbr, input logic xtk,
                       input logic [31:0] xtgt);
    reset = rst; f_valid = fv; f_pc = fpc; f_predict_valid = fpv; f_predict_addr = fpa;
    x_valid = xv; x_pc = xpc; x_is_branch = xbr; x_taken = xtk; x_target = xtgt;
  endtask

  task automatic check(input string name, input logic fbv, input logic [31:0] fbpc,
                       input logic fbt, input logic rv, input logic [31:0] ra,
                       input logic se, input logic [15:0] bc, input logic [15:0] mc,
                       input logic fr);
    nvec++;
    if (fb_valid !== fbv || fb_pc !== fbpc || fb_taken !== fbt || redirect_valid !== rv ||
        redirect_addr !== ra || sync_err !== se || branch_count !== bc ||
        mispredict_count !== mc || f_ready !== fr) begin
      nfail++;
      $display("FAIL %s: got fbv=%0b fbpc=%h fbt=%0b rv=%0b ra=%h se=%0b bc=%0d mc=%0d fr=%0b, want fbv=%0b fbpc=%h fbt=%0b rv=%0b ra=%h se=%0b bc=%0d mc=%0d fr=%0b",
               name, fb_valid, fb_pc, fb_taken, redirect_valid, redirect_addr, sync_err,
               branch_count, mispredict_count, f_ready, fbv, fbpc, fbt, rv, ra, se, bc, mc, fr);
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // correct prediction
    tv.push_back('{1, 0,0,0,0,             0,0,0,0,0,                  0,0,0,0,0,0,0,0,1});
    tv.push_back('{0, 1,'h100,1,'h200,     0,0,0,0,0,                  0,0,0,0,0,0,0,0,1});
    tv.push_back('{0, 0,0,0,0,             1,'h100,1,1,'h200,          1,'h100,1,0,0,0,1,0,1});
    // not-taken prediction, branch taken; younger entry and wrong-path push discarded
    tv.push_back('{0, 1,'h104,0,0,         0,0,0,0,0,                  0,'h100,1,0,0,0,1,0,1});
    tv.push_back('{0, 1,'h108,0,0,         0,0,0,0,0,                  0,'h100,1,0,0,0,1,0,1});
    tv.push_back('{0, 0,0,0,0,             1,'h104,1,1,'h300,          1,'h104,1,1,'h300,0,2,1,1});
    tv.push_back('{0, 1,'h200,0,0,         0,0,0,0,0,                  0,'h104,1,0,'h300,0,2,1,1});
    tv.push_back('{0, 0,0,0,0,             1,'h200,0,0,0,              0,'h104,1,0,'h300,1,2,1,1});
    // taken prediction on a non-branch
    tv.push_back('{1, 0,0,0,0,             0,0,0,0,0,                  0,0,0,0,0,0,0,0,1});
    tv.push_back('{0, 1,'h10C,1,'h400,     0,0,0,0,0,                  0,0,0,0,0,0,0,0,1});
    tv.push_back('{0, 0,0,0,0,             1,'h10C,0,0,0,              0,0,0,1,'h110,0,0,1,1});
    // fill, overflow, push+pop while full, drain in order
    tv.push_back('{1, 0,0,0,0,             0,0,0,0,0,                  0,0,0,0,0,0,0,0,1});
    tv.push_back('{0, 1,'h20,0,0,          0,0,0,0,0,                  0,0,0,0,0,0,0,0,1});
    tv.push_back('{0, 1,'h24,0,0,          0,0,0,0,0,                  0,0,0,0,0,0,0,0,1});
    tv.push_back('{0, 1,'h28,0,0,          0,0,0,0,0,                  0,0,0,0,0,0,0,0,1});
    tv.push_back('{0, 1,'h2C,0,0,          0,0,0,0,0,                  0,0,0,0,0,0,0,0,0});
    tv.push_back('{0, 1,'h30,0,0,          0,0,0,0,0,                  0,0,0,0,0,1,0,0,0});
    tv.push_back('{0, 1,'h30,0,0,          1,'h20,0,0,0,               0,0,0,0,0,1,0,0,0});
    tv.push_back('{0, 0,0,0,0,             1,'h24,1,0,'h99,            1,'h24,0,0,0,1,1,0,1});
    tv.push_back('{0, 0,0,0,0,             1,'h28,0,0,0,               0,'h24,0,0,0,1,1,0,1});
    tv.push_back('{0, 0,0,0,0,             1,'h2C,0,0,0,               0,'h24,0,0,0,1,1,0,1});
    tv.push_back('{0, 0,0,0,0,             1,'h30,0,0,0,               0,'h24,0,0,0,1,1,0,1});
    // retire while empty
    tv.push_back('{1, 0,0,0,0,             0,0,0,0,0,                  0,0,0,0,0,0,0,0,1});
    tv.push_back('{0, 0,0,0,0,             1,'h50,0,0,0,               0,0,0,0,0,1,0,0,1});
    // next-PC wraps at 2^32
    tv.push_back('{1, 0,0,0,0,             0,0,0,0,0,                  0,0,0,0,0,0,0,0,1});
    tv.push_back('{0, 1,'hFFFFFFFC,1,'h800,0,0,0,0,0,                  0,0,0,0,0,0,0,0,1});
    tv.push_back('{0, 0,0,0,0,             1,'hFFFFFFFC,1,0,'h800,     1,'hFFFFFFFC,0,1,0,0,1,1,1});
    tv.push_back('{0, 0,0,0,0,             0,0,0,0,0,                  0,'hFFFFFFFC,0,0,0,0,1,1,1});
    // PC mismatch at the head
    tv.push_back('{0, 1,'h60,0,0,          0,0,0,0,0,                  0,'hFFFFFFFC,0,0,0,0,1,1,1});
    tv.push_back('{0, 0,0,0,0,             1,'h64,0,0,0,               0,'hFFFFFFFC,0,1,'h68,1,1,2,1});
    tv.push_back('{0, 0,0,0,0,             0,0,0,0,0,                  0,'hFFFFFFFC,0,0,'h68,1,1,2,1});
    // reset in the middle of traffic wins over push and pop
    tv.push_back('{0, 1,'h70,1,'h90,       0,0,0,0,0,                  0,'hFFFFFFFC,0,0,'h68,1,1,2,1});
    tv.push_back('{0, 1,'h74,0,0,          0,0,0,0,0,                  0,'hFFFFFFFC,0,0,'h68,1,1,2,1});
    tv.push_back('{1, 1,'h78,0,0,          1,'h70,1,1,'h90,            0,0,0,0,0,0,0,0,1});
    tv.push_back('{0, 0,0,0,0,             1,'h74,0,0,0,               0,0,0,0,0,1,0,0,1});

    @(negedge clk);
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].rst, tv[i].fv, tv[i].fpc, tv[i].fpv, tv[i].fpa,
            tv[i].xv, tv[i].xpc, tv[i].xbr, tv[i].xtk, tv[i].xtgt);
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), tv[i].fbv, tv[i].fbpc, tv[i].fbt, tv[i].rv, tv[i].ra,
            tv[i].se, tv[i].bc, tv[i].mc, tv[i].fr);
    end

    // streaming push+pop of correctly predicted taken branches, wrapping the pointers
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 1, 32'h1000, 1, 32'h1008, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    for (int i = 1; i <= 12; i++) begin
      logic [31:0] prev;
      prev = 32'h1000 + 32'(4 * (i - 1));
      drive(0, (i < 12), prev + 32'd4, 1, prev + 32'd12, 1, prev, 1, 1, prev + 32'd8);
      @(posedge clk); #1;
      check($sformatf("stream%0d", i), 1'b1, prev, 1'b1, 1'b0, 32'h0, 1'b0,
            16'(i), 16'h0, 1'b1);
    end

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("stream_idle", 1'b0, 32'h102C, 1'b1, 1'b0, 32'h0, 1'b0, 16'd12, 16'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
